// File: rtl/hint_bundler_pkg.sv
// Shared core configuration plus the hint-logging constants and state type.
// Combinational definitions only; no latency or flow control.
package cvw;

    typedef struct packed {
        int XLEN;
        int LOG_HINTS;
        int MAX_BUNDLE_LEN;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{XLEN: 64, LOG_HINTS: 1, MAX_BUNDLE_LEN: 4};

    localparam int HINT_IMM_BITS = 12;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } hintstate_t;

endpackage

// File: rtl/hint_bundler_buffer.sv
// Flop array with one write port, one registered-pointer read port, and resettable pointers.
// Write lands next edge; read is combinational off the registered read pointer; no backpressure.
module hint_buffer #(
    parameter int DEPTH = 4,
    parameter int W     = 76,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic [W-1:0]  wdata,
    input  logic          rd_adv,
    input  logic          clr,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [W-1:0]  rd_data
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];

    // Payload storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr[IW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (we) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    assign rd_data = mem[rd_ptr[IW-1:0]];

endmodule

// File: rtl/hint_bundler.sv
// Packs retired logging hints into bundles and streams them out; BundleValid rises 1 cycle after close.
// Hints never stall: during drain or backpressure they are dropped and counted.
module hint_bundler
    import cvw::*;
#(
    parameter cvw_t P = CVW_DEFAULT,
    localparam int CNTW = $clog2(P.MAX_BUNDLE_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     HintValidM,
    input  logic [P.XLEN-1:0]        HintPCM,
    input  logic [HINT_IMM_BITS-1:0] HintImmM,
    input  logic                     FlushBundle,
    output logic                     BundleValid,
    input  logic                     BundleReady,
    output logic [P.XLEN-1:0]        BundlePC,
    output logic [HINT_IMM_BITS-1:0] BundleImm,
    output logic [CNTW-1:0]          BundleIdx,
    output logic                     BundleLast,
    output logic [7:0]               BundleSeq,
    output logic [15:0]              HintDropCount
);

    if (P.LOG_HINTS != 0) begin : g_on

        typedef struct packed {
            logic [P.XLEN-1:0]        pc;
            logic [HINT_IMM_BITS-1:0] imm;
        } hint_rec_t;

        hintstate_t      state;
        logic            last_q;
        logic [7:0]      seq_q;
        logic [15:0]     drop_cnt;
        logic [CNTW-1:0] count;
        logic [CNTW-1:0] rdptr;
        logic [CNTW-1:0] cnt_after;
        hint_rec_t       wr_rec;
        hint_rec_t       rd_rec;
        logic            hint_fill;
        logic            handshake;
        logic            clr;

        always_comb begin
            hint_fill  = HintValidM && (state == FILL);
            handshake  = (state == DRAIN) && BundleReady;
            clr        = handshake && last_q;
            cnt_after  = count + CNTW'(hint_fill);
            wr_rec.pc  = HintPCM;
            wr_rec.imm = HintImmM;
        end

        hint_buffer #(
            .DEPTH (P.MAX_BUNDLE_LEN),
            .W     ($bits(hint_rec_t)),
            .AW    (CNTW)
        ) u_buf (
            .clk     (clk),
            .resetn  (resetn),
            .we      (hint_fill),
            .wdata   (wr_rec),
            .rd_adv  (handshake),
            .clr     (clr),
            .wr_ptr  (count),
            .rd_ptr  (rdptr),
            .rd_data (rd_rec)
        );

        always_ff @(posedge clk) begin
            if (!resetn) begin
                state    <= FILL;
                last_q   <= 1'b0;
                seq_q    <= 8'd0;
                drop_cnt <= 16'd0;
            end else begin
                case (state)
                    FILL: begin
                        // Same-cycle hint is counted before deciding whether to close.
                        if ((cnt_after == CNTW'(P.MAX_BUNDLE_LEN)) ||
                            (FlushBundle && (cnt_after != '0))) begin
                            state  <= DRAIN;
                            last_q <= (cnt_after == CNTW'(1));
                        end
                    end
                    DRAIN: begin
                        if (HintValidM && (drop_cnt != 16'hFFFF)) begin
                            drop_cnt <= drop_cnt + 16'd1;
                        end
                        if (handshake) begin
                            if (last_q) begin
                                state  <= FILL;
                                last_q <= 1'b0;
                                seq_q  <= seq_q + 8'd1;
                            end else begin
                                last_q <= ((rdptr + CNTW'(2)) == count);
                            end
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end

        assign BundleValid   = (state == DRAIN);
        assign BundlePC      = BundleValid ? rd_rec.pc  : '0;
        assign BundleImm     = BundleValid ? rd_rec.imm : '0;
        assign BundleIdx     = rdptr;
        assign BundleLast    = last_q;
        assign BundleSeq     = seq_q;
        assign HintDropCount = drop_cnt;

    end else begin : g_off

        assign BundleValid   = 1'b0;
        assign BundlePC      = '0;
        assign BundleImm     = '0;
        assign BundleIdx     = '0;
        assign BundleLast    = 1'b0;
        assign BundleSeq     = 8'd0;
        assign HintDropCount = 16'd0;

    end

endmodule
